// File: rtl/mac_step_accumulator.sv
// Purpose: multiply-accumulate over STEPS products, one product per RUN_IN strobe.
// Latency: RESULT_OUT/STEP_OUT update one cycle after each accepted RUN_IN.
// Backpressure: none; RUN_IN low stalls indefinitely, RUN_IN in DONE only flags overrun.
module mac_step_accumulator #(
  parameter int WIDTH = 4,
  parameter int STEPS = 3,
  localparam int SW   = $clog2(STEPS + 1),
  localparam int ACCW = 2 * WIDTH + SW
) (
  input  logic             CLK,
  input  logic             RESET_IN,
  input  logic             RUN_IN,
  input  logic             CLEAR_IN,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  output logic [ACCW-1:0]  RESULT_OUT,
  output logic [SW-1:0]    STEP_OUT,
  output logic             BUSY_OUT,
  output logic             DONE_OUT,
  output logic             OVERRUN_OUT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [ACCW-1:0]   r_acc;
  logic [SW-1:0]     r_step;
  logic              r_overrun;

  logic [ACCW-1:0]   w_prod;
  logic [SW-1:0]     w_step_nxt;
  logic              w_last;

  // Product is zero-extended to the accumulator width so the sum never wraps.
  assign w_prod     = ACCW'(A_IN) * ACCW'(B_IN);
  assign w_step_nxt = r_step + 1'b1;
  assign w_last     = (w_step_nxt == SW'(STEPS));

  // Control FSM and datapath registers; clear outranks run in every state.
  always_ff @(posedge CLK or posedge RESET_IN) begin
    if (RESET_IN) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_step    <= '0;
      r_overrun <= 1'b0;
    end else if (CLEAR_IN) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_step    <= '0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (RUN_IN) begin
            r_acc   <= w_prod;
            r_step  <= SW'(1);
            r_state <= (STEPS == 1) ? DONE : ACCUM;
          end else begin
            r_acc  <= '0;
            r_step <= '0;
          end
        end
        ACCUM: begin
          if (RUN_IN) begin
            r_acc  <= r_acc + w_prod;
            r_step <= w_step_nxt;
            if (w_last) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          // Final sum is frozen; extra strobes are only recorded.
          if (RUN_IN) begin
            r_overrun <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_acc   <= '0;
          r_step  <= '0;
        end
      endcase
    end
  end

  assign RESULT_OUT  = r_acc;
  assign STEP_OUT    = r_step;
  assign BUSY_OUT    = (r_state == ACCUM);
  assign DONE_OUT    = (r_state == DONE);
  assign OVERRUN_OUT = r_overrun;

endmodule

// File: tb/tb_mac_step_accumulator.sv
// Purpose: directed table-driven check of mac_step_accumulator at default parameters.
// Latency: expects outputs one cycle after each driven input row.
// Backpressure: n/a; stimulus applied every cycle on the falling edge.
module tb_mac_step_accumulator;

  logic       CLK;
  logic       RESET_IN;
  logic       RUN_IN;
  logic       CLEAR_IN;
  logic [3:0] A_IN;
  logic [3:0] B_IN;
  logic [9:0] RESULT_OUT;
  logic [1:0] STEP_OUT;
  logic       BUSY_OUT;
  logic       DONE_OUT;
  logic       OVERRUN_OUT;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic       run;
    logic       clr;
    logic [3:0] a;
    logic [3:0] b;
    int         res;
    int         step;
    logic       busy;
    logic       done;
    logic       ovr;
  } vec_t;

  vec_t vecs[$];

  mac_step_accumulator dut (
    .CLK         (CLK),
    .RESET_IN    (RESET_IN),
    .RUN_IN      (RUN_IN),
    .CLEAR_IN    (CLEAR_IN),
    .A_IN        (A_IN),
    .B_IN        (B_IN),
    .RESULT_OUT  (RESULT_OUT),
    .STEP_OUT    (STEP_OUT),
    .BUSY_OUT    (BUSY_OUT),
    .DONE_OUT    (DONE_OUT),
    .OVERRUN_OUT (OVERRUN_OUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int idx, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input int res, input int step,
                         input logic busy, input logic done, input logic ovr);
    chk({tag, " result"},  idx, int'(RESULT_OUT),  res);
    chk({tag, " step"},    idx, int'(STEP_OUT),    step);
    chk({tag, " busy"},    idx, int'(BUSY_OUT),    int'(busy));
    chk({tag, " done"},    idx, int'(DONE_OUT),    int'(done));
    chk({tag, " overrun"}, idx, int'(OVERRUN_OUT), int'(ovr));
  endtask

  task automatic add(input logic run, input logic clr, input int a, input int b,
                     input int res, input int step, input logic busy, input logic done,
                     input logic ovr);
    vec_t v;
    v.run  = run;
    v.clr  = clr;
    v.a    = 4'(a);
    v.b    = 4'(b);
    v.res  = res;
    v.step = step;
    v.busy = busy;
    v.done = done;
    v.ovr  = ovr;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs on the falling edge, sample just after the rising edge.
  task automatic step_cycle(input logic run, input logic clr, input int a, input int b);
    @(negedge CLK);
    RUN_IN   = run;
    CLEAR_IN = clr;
    A_IN     = 4'(a);
    B_IN     = 4'(b);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    RESET_IN = 1'b1;
    RUN_IN   = 1'b0;
    CLEAR_IN = 1'b0;
    A_IN     = 4'd0;
    B_IN     = 4'd0;

    //   run clr  a   b   res step busy done ovr
    // basic run
    add(1, 0,  3,  5,  15, 1, 1, 0, 0);
    add(1, 0,  2,  7,  29, 2, 1, 0, 0);
    add(1, 0, 15, 15, 254, 3, 0, 1, 0);
    // overrun in DONE, result frozen, operands ignored
    add(1, 0,  1,  1, 254, 3, 0, 1, 1);
    add(0, 0,  9,  9, 254, 3, 0, 1, 1);
    // clear returns everything to zero
    add(0, 1,  0,  0,   0, 0, 0, 0, 0);
    add(0, 0,  7,  7,   0, 0, 0, 0, 0);
    // stall between steps 1 and 2
    add(1, 0,  3,  5,  15, 1, 1, 0, 0);
    add(0, 0,  9,  9,  15, 1, 1, 0, 0);
    add(0, 0,  9,  9,  15, 1, 1, 0, 0);
    add(0, 0,  9,  9,  15, 1, 1, 0, 0);
    add(0, 0,  9,  9,  15, 1, 1, 0, 0);
    add(1, 0,  2,  7,  29, 2, 1, 0, 0);
    add(1, 0, 15, 15, 254, 3, 0, 1, 0);
    // clear with run in DONE: clear wins, no overrun
    add(1, 1,  4,  4,   0, 0, 0, 0, 0);
    // maximum value
    add(1, 0, 15, 15, 225, 1, 1, 0, 0);
    add(1, 0, 15, 15, 450, 2, 1, 0, 0);
    add(1, 0, 15, 15, 675, 3, 0, 1, 0);
    add(0, 1,  0,  0,   0, 0, 0, 0, 0);
    // clear/run collision in ACCUM
    add(1, 0,  4,  4,  16, 1, 1, 0, 0);
    add(1, 1,  5,  5,   0, 0, 0, 0, 0);
    add(0, 0,  5,  5,   0, 0, 0, 0, 0);
    add(1, 0,  2,  3,   6, 1, 1, 0, 0);
    add(0, 1,  0,  0,   0, 0, 0, 0, 0);

    // Reset state while reset is held.
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RESET_IN = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step_cycle(vecs[i].run, vecs[i].clr, int'(vecs[i].a), int'(vecs[i].b));
      chk_all("vec", i, vecs[i].res, vecs[i].step, vecs[i].busy, vecs[i].done, vecs[i].ovr);
    end

    // Async reset between edges after step 2.
    step_cycle(1, 0, 3, 5);
    chk("areset pre result", 0, int'(RESULT_OUT), 15);
    step_cycle(1, 0, 2, 7);
    chk("areset pre result", 1, int'(RESULT_OUT), 29);
    chk("areset pre step",   1, int'(STEP_OUT),   2);
    @(negedge CLK);
    RUN_IN = 1'b0;
    #1;
    RESET_IN = 1'b1;
    #1;
    chk_all("areset", 0, 0, 0, 0, 0, 0);
    #1;
    RESET_IN = 1'b0;
    step_cycle(1, 0, 1, 1);
    chk_all("post reset", 0, 1, 1, 1, 0, 0);
    step_cycle(1, 0, 1, 1);
    chk_all("post reset", 1, 2, 2, 1, 0, 0);
    step_cycle(1, 0, 1, 1);
    chk_all("post reset", 2, 3, 3, 0, 1, 0);
    step_cycle(0, 0, 0, 0);
    chk_all("post reset", 3, 3, 3, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
